// File: rtl/fp_exception_unit.sv
`timescale 1ns/1ps
// Two-stage special-case / exception detector for the minifloat FPU: classifies operands,
// picks the IEEE special result and {invalid, divzero}, and keeps the sticky status flags.
module fp_exception_unit #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_op,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_special,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic [1:0]             out_exc,
    input  logic                   dp_flags_valid,
    input  logic [2:0]             dp_flags,
    input  logic                   clear_flags,
    output logic [4:0]             sticky_flags
);
    localparam int W = 1 + EXP_W + MAN_W;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [EXP_W-1:0] EXP_MAX  = '1;
    localparam logic [MAN_W-1:0] QNAN_MAN = {1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-1:0]     NAN_VAL  = {1'b0, EXP_MAX, QNAN_MAN};

    typedef enum logic [1:0] {CL_FIN, CL_ZERO, CL_INF, CL_NAN} cls_t;

    typedef struct packed {
        logic           special;
        logic [W-1:0]   result;
        logic [1:0]     exc;
    } dec_t;

    function automatic cls_t classify(input logic [W-1:0] x);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        e = x[W-2 -: EXP_W];
        m = x[MAN_W-1:0];
        if (e == EXP_MAX) return (m == '0) ? CL_INF : CL_NAN;
        if (e == '0 && m == '0) return CL_ZERO;
        return CL_FIN;
    endfunction

    function automatic dec_t hit(input logic [W-1:0] r, input logic [1:0] e);
        dec_t d;
        d.special = 1'b1;
        d.result  = r;
        d.exc     = e;
        return d;
    endfunction

    function automatic logic [W-1:0] inf_of(input logic s);
        return {s, EXP_MAX, {MAN_W{1'b0}}};
    endfunction

    function automatic logic [W-1:0] zero_of(input logic s);
        return {s, {(W-1){1'b0}}};
    endfunction

    function automatic dec_t decide(input cls_t ca, input cls_t cb, input logic sa,
                                    input logic sbr, input logic [1:0] op);
        dec_t d;
        logic sb, sx;
        d  = '0;
        sb = sbr ^ (op == OP_SUB);
        sx = sa ^ sbr;
        if (ca == CL_NAN || cb == CL_NAN) begin
            d = hit(NAN_VAL, 2'b10);
        end else begin
            case (op)
                OP_ADD, OP_SUB: begin
                    if (ca == CL_INF && cb == CL_INF)
                        d = (sa != sb) ? hit(NAN_VAL, 2'b10) : hit(inf_of(sa), 2'b00);
                    else if (ca == CL_INF) d = hit(inf_of(sa), 2'b00);
                    else if (cb == CL_INF) d = hit(inf_of(sb), 2'b00);
                end
                OP_MUL: begin
                    if ((ca == CL_INF && cb == CL_ZERO) || (ca == CL_ZERO && cb == CL_INF))
                        d = hit(NAN_VAL, 2'b10);
                    else if (ca == CL_INF || cb == CL_INF)   d = hit(inf_of(sx), 2'b00);
                    else if (ca == CL_ZERO || cb == CL_ZERO) d = hit(zero_of(sx), 2'b00);
                end
                default: begin
                    // x/0 raises divzero only for a finite dividend; Inf/0 is exact.
                    if ((ca == CL_ZERO && cb == CL_ZERO) || (ca == CL_INF && cb == CL_INF))
                        d = hit(NAN_VAL, 2'b10);
                    else if (cb == CL_ZERO) d = hit(inf_of(sx), {1'b0, ca == CL_FIN});
                    else if (ca == CL_INF)  d = hit(inf_of(sx), 2'b00);
                    else if (cb == CL_INF || ca == CL_ZERO) d = hit(zero_of(sx), 2'b00);
                end
            endcase
        end
        return d;
    endfunction

    logic       adv;
    logic       vld_p1, vld_p2;
    cls_t       cls_a_p1, cls_b_p1;
    logic       sa_p1, sb_p1;
    logic [1:0] op_p1;
    dec_t       dec_p2;
    logic [4:0] sticky_q, sticky_nxt;

    assign adv      = !vld_p2 || out_ready;
    assign in_ready = adv;

    // Stage 1: operand classification, signs and op
    always_ff @(posedge clk) begin
        if (adv) begin
            cls_a_p1 <= classify(in_a);
            cls_b_p1 <= classify(in_b);
            sa_p1    <= in_a[W-1];
            sb_p1    <= in_b[W-1];
            op_p1    <= in_op;
        end
    end

    always_comb begin
        sticky_nxt = clear_flags ? 5'b0 : sticky_q;
        if (vld_p2 && out_ready) sticky_nxt[4:3] = sticky_nxt[4:3] | dec_p2.exc;
        if (dp_flags_valid)      sticky_nxt[2:0] = sticky_nxt[2:0] | dp_flags;
    end

    // Stage 2: registered decision and sticky status
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            dec_p2   <= '0;
            sticky_q <= '0;
        end else begin
            if (adv) begin
                vld_p1 <= in_valid;
                vld_p2 <= vld_p1;
                dec_p2 <= vld_p1 ? decide(cls_a_p1, cls_b_p1, sa_p1, sb_p1, op_p1) : '0;
            end
            sticky_q <= sticky_nxt;
        end
    end

    assign out_valid    = vld_p2;
    assign out_special  = dec_p2.special;
    assign out_result   = dec_p2.result;
    assign out_exc      = dec_p2.exc;
    assign sticky_flags = sticky_q;

endmodule

// File: doc/fp_exception_unit.md
Name: fp_exception_unit

Overview:
Parametrised, pipelined special-case and exception detector for the minifloat FPU; successor to the combinational single-flag exception check.
Classifies both operands, decides the IEEE-style special result and per-operation exception flags for ADD/SUB/MUL/DIV, and accumulates sticky status flags.
Sits in front of the arithmetic datapath. When out_special=1, the FPU uses out_result and bypasses the datapath result.

Parameters:
EXP_W, 4, exponent width in bits
MAN_W, 3, mantissa (fraction) width in bits; word width W = 1+EXP_W+MAN_W (default 8)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  operand pair valid
in_ready  out  1  unit accepts operands this cycle
in_op  in  2  operation: 00 ADD, 01 SUB, 10 MUL, 11 DIV
in_a  in  W  operand A {sign, exp, man}
in_b  in  W  operand B
out_valid  out  1  decision valid
out_ready  in  1  consumer accepts decision
out_special  out  1  special case; out_result must be used
out_result  out  W  special-case result (0 when out_special=0)
out_exc  out  2  {invalid, divzero} for this operation
dp_flags_valid  in  1  datapath reports flags this cycle
dp_flags  in  3  datapath {overflow, underflow, inexact}
clear_flags  in  1  synchronous clear of sticky flags
sticky_flags  out  5  {invalid, divzero, overflow, underflow, inexact}

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset state: out_valid=0, out_special=0, out_result=0, out_exc=0, sticky_flags=0. Both pipeline stage valids are 0.
- Operand classification:
  - Exponent all ones, man=0: INF.
  - Exponent all ones, man≠0: NaN.
  - Exponent 0, man=0: ZERO.
  - Anything else, including subnormals: FINITE.
- Constants:
  - Canonical NaN = {0, all-ones exp, man MSB=1, rest 0}; 0x7C at default width.
  - Inf = {s, all-ones exp, 0}.
  - Zero = {s, 0, 0}.
- Pipeline:
  - Stage 1 registers the classification, signs and op.
  - Stage 2 registers the decision.
  - Latency is exactly 2 cycles from the accept edge to out_valid when there is no stall.
- Handshake:
  - adv = !out_valid | out_ready; in_ready = adv.
  - Both stages advance only when adv=1, so the whole pipe stalls together.
  - Accept occurs when in_valid & in_ready.
  - Outputs hold stable while out_valid & !out_ready.
  - Full throughput: 1 operation per cycle.
- Decision rules. sb = b.sign XOR (op==SUB), sx = a.sign XOR b.sign.
  - Either operand NaN: special, result NaN, invalid=1.
  - ADD/SUB, INF with INF and a.sign≠sb: NaN, invalid. Same sign: Inf(a.sign).
  - ADD/SUB, exactly one operand INF: Inf(sign of the INF operand; sb for B). Other ADD/SUB cases are not special.
  - MUL, INF×ZERO either order: NaN, invalid.
  - MUL, INF with FINITE or INF: Inf(sx).
  - MUL, ZERO with FINITE or ZERO: Zero(sx). FINITE×FINITE is not special.
  - DIV: 0/0 → NaN, invalid. Inf/Inf → NaN, invalid.
  - DIV: FINITE/0 → Inf(sx), divzero=1. Inf/0 → Inf(sx), divzero=0.
  - DIV: Inf/FINITE → Inf(sx). FINITE/Inf → Zero(sx). 0/FINITE and 0/Inf → Zero(sx).
  - DIV: FINITE/FINITE is not special.
  - Not special: out_special=0, out_result=0, out_exc=0.
- Sticky flags:
  - On an output handshake, OR out_exc into bits [4:3].
  - When dp_flags_valid=1, OR dp_flags into bits [2:0].
  - clear_flags zeroes all bits. If a set event occurs in the same cycle, set wins for the bits being set.
  - Flags only change at these events; they never self-clear.
- Reset mid-operation: the in-flight operations are discarded. No flags are set and out_valid=0 in the cycle after rst.

Test Plan:
- ADD +inf (0x78) + 0x00 → 2 cycles later out_special=1, out_result=0x78, out_exc=00, sticky_flags=0.
- SUB 0x78 − 0x78 → out_result=0x7C, out_exc=10, sticky_flags=10000. Then MUL 0x78 × 0x00 → 0x7C, invalid.
- DIV 0x38 / 0x00 → 0x78, out_exc=01, sticky bit3 set. DIV 0xB8 / 0x00 → 0xF8. DIV 0x00 / 0x00 → 0x7C, invalid.
- Back-to-back stream of 4 ops with out_ready=1 → 4 results on consecutive cycles in order. Hold out_ready=0 for 3 cycles → in_ready=0 and out_result stable; results resume with no loss.
- Assert clear_flags in the same cycle as a DIV-by-zero handshake and dp_flags=101 with valid → sticky_flags=01101 next cycle. A clear with no events → 00000.
- Assert rst while 2 ops are in flight → out_valid=0 and sticky_flags=0 next cycle, with no stale result emitted.
